// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle from uart_rx_cfg to its consumer: a one-cycle valid strobe
// with the parallel word and the per-frame error flags.
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 o_Rx_DV;
   logic [DATA_BITS-1:0] o_Rx_Byte;
   logic                 o_Parity_Err;
   logic                 o_Frame_Err;

   modport master (
      output o_Rx_DV,
      output o_Rx_Byte,
      output o_Parity_Err,
      output o_Frame_Err
   );

   modport slave (
      input o_Rx_DV,
      input o_Rx_Byte,
      input o_Parity_Err,
      input o_Frame_Err
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional odd/even parity, 1 or 2 stop
// bits, 3-sample majority vote per bit, parity/framing errors reported with each word.
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 54,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic          i_Clock,
   input  logic          i_Rst_n,
   input  logic          i_Rx_Serial,
   uart_rx_cfg_if.master rx_if
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  FULL_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_CLEANUP
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] word;
   logic                 par_err;
   logic                 stop_err;

   logic                 meta_rx;
   logic                 sync_rx;
   logic [2:0]           hist;
   logic                 vote;

   // Two-flop synchroniser plus a 3-deep history; all reset to the idle (high) level.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_rx <= 1'b1;
         sync_rx <= 1'b1;
         hist    <= 3'b111;
      end else begin
         // NOTE: sequential state always uses <=, so every flop samples the pre-edge values.
         meta_rx <= i_Rx_Serial;
         sync_rx <= meta_rx;
         hist    <= {hist[1:0], sync_rx};
      end
   end

   assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state              <= S_IDLE;
         cnt                <= '0;
         bit_idx            <= '0;
         word               <= '0;
         par_err            <= 1'b0;
         stop_err           <= 1'b0;
         rx_if.o_Rx_DV      <= 1'b0;
         rx_if.o_Rx_Byte    <= '0;
         rx_if.o_Parity_Err <= 1'b0;
         rx_if.o_Frame_Err  <= 1'b0;
      end else begin
         // NOTE: defaulting the strobe low here makes it a pulse that cannot stick high.
         rx_if.o_Rx_DV <= 1'b0;

         case (state)
            S_IDLE: begin
               cnt      <= '0;
               bit_idx  <= '0;
               par_err  <= 1'b0;
               stop_err <= 1'b0;
               if (!sync_rx) state <= S_START;
            end

            // A low that has vanished by mid-start-bit is a glitch, not a frame.
            S_START: begin
               if (cnt == HALF_CNT) begin
                  cnt   <= '0;
                  state <= vote ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (cnt == FULL_CNT) begin
                  cnt  <= '0;
                  word <= {vote, word[DATA_BITS-1:1]};
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (cnt == FULL_CNT) begin
                  cnt     <= '0;
                  par_err <= (PARITY == 1) ? ~(^word ^ vote) : (^word ^ vote);
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // Outputs are loaded together at mid-final-stop-bit, leaving half a bit
            // of slack to re-arm for a back-to-back start bit.
            S_STOP: begin
               if (cnt == FULL_CNT) begin
                  cnt <= '0;
                  if (bit_idx == LAST_STOP) begin
                     rx_if.o_Rx_DV      <= 1'b1;
                     rx_if.o_Rx_Byte    <= word;
                     rx_if.o_Parity_Err <= par_err;
                     rx_if.o_Frame_Err  <= stop_err | ~vote;
                     state              <= S_CLEANUP;
                  end else begin
                     stop_err <= stop_err | ~vote;
                     bit_idx  <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // Waiting for a high line here is what stops a break from re-triggering.
            S_CLEANUP: begin
               if (sync_rx) state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2) driven by directed and
// random frames, checked against a frame-level model and latency formula.
module tb_uart_rx_cfg;

   localparam int A_CPB = 8,  A_BITS = 8, A_PAR = 0, A_STOP = 1;
   localparam int B_CPB = 16, B_BITS = 8, B_PAR = 2, B_STOP = 1;
   localparam int C_CPB = 10, C_BITS = 7, C_PAR = 1, C_STOP = 2;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      int         stamp;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rx_a, rx_b, rx_c;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   int   failed = 0;

   rec_t mon_a[$];
   rec_t mon_b[$];
   rec_t mon_c[$];
   rec_t exp_q[3][$];
   int   rd[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_cfg_if #(.DATA_BITS(A_BITS)) if_a ();
   uart_rx_cfg_if #(.DATA_BITS(B_BITS)) if_b ();
   uart_rx_cfg_if #(.DATA_BITS(C_BITS)) if_c ();

   uart_rx_cfg #(.CLKS_PER_BIT(A_CPB), .DATA_BITS(A_BITS), .PARITY(A_PAR), .STOP_BITS(A_STOP))
      dut_a (.i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_a), .rx_if(if_a.master));
   uart_rx_cfg #(.CLKS_PER_BIT(B_CPB), .DATA_BITS(B_BITS), .PARITY(B_PAR), .STOP_BITS(B_STOP))
      dut_b (.i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_b), .rx_if(if_b.master));
   uart_rx_cfg #(.CLKS_PER_BIT(C_CPB), .DATA_BITS(C_BITS), .PARITY(C_PAR), .STOP_BITS(C_STOP))
      dut_c (.i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_c), .rx_if(if_c.master));

   function automatic rec_t mk_rec(logic [8:0] d, logic p, logic f, int st);
      rec_t r;
      r.data  = d;
      r.perr  = p;
      r.ferr  = f;
      r.stamp = st;
      return r;
   endfunction

   // Stamp = number of the first rising edge at which the strobe reads high.
   always @(negedge clk) begin
      if (if_a.o_Rx_DV === 1'b1)
         mon_a.push_back(mk_rec(9'(if_a.o_Rx_Byte), if_a.o_Parity_Err, if_a.o_Frame_Err, cyc + 1));
      if (if_b.o_Rx_DV === 1'b1)
         mon_b.push_back(mk_rec(9'(if_b.o_Rx_Byte), if_b.o_Parity_Err, if_b.o_Frame_Err, cyc + 1));
      if (if_c.o_Rx_DV === 1'b1)
         mon_c.push_back(mk_rec(9'(if_c.o_Rx_Byte), if_c.o_Parity_Err, if_c.o_Frame_Err, cyc + 1));
   end

   function automatic int cpb_of(int s);
      case (s) 0: return A_CPB; 1: return B_CPB; default: return C_CPB; endcase
   endfunction
   function automatic int bits_of(int s);
      case (s) 0: return A_BITS; 1: return B_BITS; default: return C_BITS; endcase
   endfunction
   function automatic int par_of(int s);
      case (s) 0: return A_PAR; 1: return B_PAR; default: return C_PAR; endcase
   endfunction
   function automatic int stop_of(int s);
      case (s) 0: return A_STOP; 1: return B_STOP; default: return C_STOP; endcase
   endfunction
   function automatic int lat_of(int s);
      int n;
      n = bits_of(s) + ((par_of(s) != 0) ? 1 : 0) + stop_of(s);
      return 3 + ((cpb_of(s) - 1) / 2 + 1) + n * cpb_of(s);
   endfunction
   function automatic int mon_size(int s);
      case (s) 0: return mon_a.size(); 1: return mon_b.size(); default: return mon_c.size(); endcase
   endfunction
   function automatic rec_t mon_get(int s, int i);
      case (s) 0: return mon_a[i]; 1: return mon_b[i]; default: return mon_c[i]; endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int s, input logic v);
      case (s)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   // Sends one frame and records what a correct receiver must report for it.
   task automatic send_frame(input int s, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stops, input int glitch_bit);
      int         c;
      int         ones;
      logic       v;
      logic [8:0] mask;
      rec_t       e;
      c    = cpb_of(s);
      mask = 9'((1 << bits_of(s)) - 1);
      drive(s, 1'b0);
      e.stamp = cyc + 1;
      hold(c);
      for (int i = 0; i < bits_of(s); i++) begin
         v = data[i];
         drive(s, v);
         if (i == glitch_bit) begin
            hold(2);
            drive(s, ~v);
            hold(1);
            drive(s, v);
            hold(c - 3);
         end else begin
            hold(c);
         end
      end
      if (par_of(s) != 0) begin
         drive(s, pbit);
         hold(c);
      end
      for (int i = 0; i < stop_of(s); i++) begin
         drive(s, stops[i]);
         hold(c);
      end
      ones   = $countones(data & mask) + int'(pbit);
      e.data = data & mask;
      case (par_of(s))
         1:       e.perr = (ones % 2 == 0);
         2:       e.perr = (ones % 2 == 1);
         default: e.perr = 1'b0;
      endcase
      e.ferr = (stops[0] == 1'b0) || (stop_of(s) == 2 && stops[1] == 1'b0);
      exp_q[s].push_back(e);
   endtask

   task automatic expect_frames(input int s, input string tag);
      rec_t e, m;
      int   lat, f;
      f = lat_of(s);
      check({tag, "_dv_count"}, 32'(mon_size(s) - rd[s]), 32'(exp_q[s].size()));
      while (exp_q[s].size() > 0 && rd[s] < mon_size(s)) begin
         e = exp_q[s].pop_front();
         m = mon_get(s, rd[s]);
         rd[s]++;
         check({tag, "_byte"}, 32'(m.data), 32'(e.data));
         check({tag, "_perr"}, 32'(m.perr), 32'(e.perr));
         check({tag, "_ferr"}, 32'(m.ferr), 32'(e.ferr));
         lat = m.stamp - e.stamp;
         check($sformatf("%s_latency_%0d_vs_%0d", tag, lat, f),
               32'(lat >= f - 1 && lat <= f + 1), 32'd1);
      end
      exp_q[s].delete();
      rd[s] = mon_size(s);
   endtask

   task automatic check_last(input int s, input string tag, input logic [8:0] b,
                             input logic p, input logic f);
      rec_t m;
      if (mon_size(s) > 0) begin
         m = mon_get(s, mon_size(s) - 1);
         check({tag, "_byte_exact"}, 32'(m.data), 32'(b));
         check({tag, "_perr_exact"}, 32'(m.perr), 32'(p));
         check({tag, "_ferr_exact"}, 32'(m.ferr), 32'(f));
      end
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_dv"},   32'(if_a.o_Rx_DV),      32'd0);
      check({tag, "_byte"}, 32'(if_a.o_Rx_Byte),    32'd0);
      check({tag, "_perr"}, 32'(if_a.o_Parity_Err), 32'd0);
      check({tag, "_ferr"}, 32'(if_a.o_Frame_Err),  32'd0);
   endtask

   initial begin
      logic [1:0] st;
      logic [7:0] pre;
      rst_n = 1'b0;
      rx_a  = 1'b1;
      rx_b  = 1'b1;
      rx_c  = 1'b1;
      rd    = '{0, 0, 0};
      hold(3);
      check_a_zero("reset_a");
      check("reset_b_dv",   32'(if_b.o_Rx_DV),   32'd0);
      check("reset_c_byte", 32'(if_c.o_Rx_Byte), 32'd0);
      rst_n = 1'b1;
      hold(4);

      // 8N1 basic frame with latency
      send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
      hold(A_CPB);
      expect_frames(0, "a5");
      check_last(0, "a5", 9'h0A5, 1'b0, 1'b0);

      // 8E1: wrong then correct parity bit
      send_frame(1, 9'h03C, 1'b1, 2'b11, -1);
      hold(B_CPB);
      expect_frames(1, "e1_bad_par");
      check_last(1, "e1_bad_par", 9'h03C, 1'b1, 1'b0);
      send_frame(1, 9'h03C, 1'b0, 2'b11, -1);
      hold(B_CPB);
      expect_frames(1, "e1_good_par");
      check_last(1, "e1_good_par", 9'h03C, 1'b0, 1'b0);

      // 7O2: second stop low, then a long break
      send_frame(2, 9'h055, 1'b1, 2'b01, -1);
      expect_frames(2, "o2_stop_low");
      check_last(2, "o2_stop_low", 9'h055, 1'b0, 1'b1);
      hold(3 * (1 + C_BITS + 1 + C_STOP) * C_CPB);
      expect_frames(2, "o2_break");
      drive(2, 1'b1);
      hold(2 * C_CPB);
      expect_frames(2, "o2_break_release");
      send_frame(2, 9'($urandom), 1'($urandom), 2'b11, -1);
      hold(C_CPB);
      expect_frames(2, "o2_recover");

      // Glitch rejection on the 8N1 receiver
      drive(0, 1'b0);
      hold(1);
      drive(0, 1'b1);
      hold(2 * A_CPB);
      expect_frames(0, "idle_glitch");
      send_frame(0, 9'h000, 1'b0, 2'b11, 3);
      hold(A_CPB);
      expect_frames(0, "data_glitch");
      check_last(0, "data_glitch", 9'h000, 1'b0, 1'b0);

      // Random frames with occasional bad stop bits
      for (int k = 0; k < 6; k++) begin
         for (int s = 0; s < 3; s++) begin
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(s, 9'($urandom), 1'($urandom), st, -1);
            drive(s, 1'b1);
            hold(cpb_of(s));
            expect_frames(s, $sformatf("rnd_s%0d_k%0d", s, k));
         end
      end

      // Reset mid-frame: preload non-zero outputs, then abort during data bit 4
      send_frame(0, 9'h0C3, 1'b0, 2'b00, -1);
      drive(0, 1'b1);
      hold(A_CPB);
      expect_frames(0, "pre_reset");
      check_last(0, "pre_reset", 9'h0C3, 1'b0, 1'b1);
      pre = 8'h5A;
      drive(0, 1'b0);
      hold(A_CPB);
      for (int i = 0; i < 4; i++) begin
         drive(0, pre[i]);
         hold(A_CPB);
      end
      drive(0, pre[4]);
      hold(A_CPB / 2);
      rst_n = 1'b0;
      hold(2);
      check_a_zero("in_reset");
      rst_n = 1'b1;
      drive(0, 1'b1);
      hold(1);
      check_a_zero("after_reset");
      hold(12 * A_CPB);
      expect_frames(0, "reset_abort");
      send_frame(0, 9'h081, 1'b0, 2'b11, -1);
      hold(A_CPB);
      expect_frames(0, "post_reset_81");
      check_last(0, "post_reset_81", 9'h081, 1'b0, 1'b0);

      // Back-to-back frames with no idle gap
      send_frame(0, 9'h001, 1'b0, 2'b11, -1);
      send_frame(0, 9'h0FE, 1'b0, 2'b11, -1);
      send_frame(0, 9'h07E, 1'b0, 2'b11, -1);
      hold(A_CPB);
      expect_frames(0, "b2b");
      check_last(0, "b2b_last", 9'h07E, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the FPGA host link, replacing the fixed 8N1 receiver. Supports configurable data width, optional odd/even parity and one or two stop bits. Data, parity and stop bits are sampled with a 3-sample majority vote. Parity and framing errors are reported alongside each received word. The block feeds the command decoder the same way as the current receiver: a one-cycle valid strobe with parallel data.

## Interface
- CLKS_PER_BIT, 54, clock cycles per bit, i.e. (f_i_Clock / baud); legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- i_Clock  in  1  single clock; all logic on its rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- o_Rx_DV  out  1  one-cycle strobe: a frame has completed.
- o_Rx_Byte  out  DATA_BITS  received word, LSB = first bit on the line.
- o_Parity_Err  out  1  parity mismatch on the frame just strobed; always 0 when PARITY=0.
- o_Frame_Err  out  1  at least one stop bit sampled low on the frame just strobed.

## Operation
- Input is double-registered into sync_rx; sync reset value is 1.
- A 3-bit history register shifts in sync_rx every cycle.
- vote = majority of the 3 history bits.
- Bit counter width is $clog2(CLKS_PER_BIT); it always compares against CLKS_PER_BIT-1 or (CLKS_PER_BIT-1)/2 and never wraps.
- States and transitions:
  - IDLE: clear the counter and bit index. Go to START when sync_rx = 0.
  - START: count to (CLKS_PER_BIT-1)/2. If vote = 0, clear the counter and go to DATA. Otherwise go to IDLE (glitch rejected; no strobe, no error).
  - DATA: count to CLKS_PER_BIT-1, then shift vote into the word (LSB first) and clear the counter. After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
  - PARITY: count to CLKS_PER_BIT-1, then capture vote as the parity bit.
    - Odd parity: the error bit is 1 when XOR(data, parity bit) = 0.
    - Even parity: the error bit is 1 when XOR(data, parity bit) = 1.
  - STOP: for each of STOP_BITS bits, count to CLKS_PER_BIT-1 and sample vote. The frame error bit is set if any stop sample is 0. After the last stop sample:
    - drive o_Rx_DV = 1;
    - load o_Rx_Byte, o_Parity_Err and o_Frame_Err together;
    - go to CLEANUP.
  - CLEANUP: o_Rx_DV returns to 0. Stay here until sync_rx = 1, then go to IDLE. A held-low line (break) yields exactly one framing-error strobe and no re-trigger.
  - Undefined state encodings go to IDLE.
- o_Rx_Byte and both error flags hold their values until the next strobe; they update only in the strobe cycle.

## Timing
- Reset (async assert, any cycle):
  - state = IDLE, counter = 0, bit index = 0;
  - sync registers and history = all 1s;
  - o_Rx_DV = 0, o_Rx_Byte = 0, o_Parity_Err = 0, o_Frame_Err = 0.
- Reset mid-frame aborts the frame with no strobe. Outputs read the reset values on the first cycle after i_Rst_n deasserts.
- Start-to-strobe latency is nominally 3 + ((CLKS_PER_BIT-1)/2 + 1) + N*CLKS_PER_BIT cycles, where N = DATA_BITS + (PARITY != 0) + STOP_BITS, measured from the first i_Clock edge at which i_Rx_Serial is low. Bench tolerance is ±1 cycle.
- The strobe occurs at mid-final-stop-bit. The next start bit is accepted as soon as the line is high again, so back-to-back frames with no idle gap are received without loss.
- The start glitch filter rejects lows shorter than 2 cycles at the start-bit midpoint.
- There is no backpressure: the consumer must take o_Rx_Byte on the o_Rx_DV cycle.

## Test plan
- 8N1, CLKS_PER_BIT=8, send 0xA5 -> one o_Rx_DV pulse, o_Rx_Byte = 0xA5, both error flags 0, latency within ±1 of the formula.
- 8E1, CLKS_PER_BIT=16:
  - send 0x3C with parity bit 1 -> DV, o_Rx_Byte = 0x3C, o_Parity_Err = 1;
  - resend with parity bit 0 -> o_Parity_Err = 0.
- 7O2, CLKS_PER_BIT=10, send 0x55 with the second stop bit low -> DV, o_Rx_Byte = 0x55, o_Frame_Err = 1. Then hold the line low for 3 frame times -> no further DV until the line returns high.
- 1-cycle low glitch, then a 1-cycle high glitch mid-data-bit, at CLKS_PER_BIT=8:
  - glitch on the idle line -> no DV;
  - glitch inside bit 3 of 0x00 -> o_Rx_Byte = 0x00 (vote suppresses it).
- Assert i_Rst_n low during data bit 4 of a frame -> no DV, all outputs 0. The next full frame, 0x81, is received correctly.
- Send 0x01, 0xFE, 0x7E back-to-back with no idle gap (8N1) -> three DV pulses carrying those values in order, no errors.
